rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: a_valid  in  1  requester A (ALU writeback) has a write pending.
REQ-004 SHALL have ports: a_rd  in  5  requester A destination register.
REQ-005 SHALL have ports: a_data  in  32  requester A write data.
REQ-006 SHALL have ports: a_ready  out  1  requester A write accepted this cycle.
REQ-007 SHALL have ports: b_valid, b_rd, b_data, b_ready  as for A (load/mul-div writeback).
REQ-008 SHALL have ports: iss_valid  in  1  an instruction with a destination issues this cycle.
REQ-009 SHALL have ports: iss_rd  in  5  destination of the issuing instruction.
REQ-010 SHALL have ports: rf_we  out  1  register-file write enable.
REQ-011 SHALL have ports: rf_wa  out  5  register-file write address.
REQ-012 SHALL have ports: rf_wd  out  32  register-file write data.
REQ-013 SHALL have ports: busy  out  32  per-register pending-write scoreboard, bit r = xr pending.

Function
REQ-014 Handshake SHALL complete on a requester when valid && ready are both high at a rising edge; ready SHALL be combinational from valid and the arbitration pointer only.
REQ-015 At most one of a_ready, b_ready SHALL be high in any cycle.
REQ-016 Single valid requester SHALL be granted in the same cycle (ready=1).
REQ-017 Both valid: grant SHALL go to the requester not granted most recently (round-robin pointer `last`); `last` updates only on a completed handshake.
REQ-018 Accepted write SHALL appear on rf_we/rf_wa/rf_wd in the following cycle (registered output stage, 1-cycle latency); rf_we SHALL be low in cycles with no handshake on the previous edge.
REQ-019 Accepted write with rd=0 SHALL complete the handshake but SHALL drive rf_we=0.
REQ-020 busy[r] SHALL set at the edge where iss_valid=1 and iss_rd=r, r!=0.
REQ-021 busy[r] SHALL clear at the edge where rf_we=1 and rf_wa=r.
REQ-022 Set and clear of the same r on the same edge: set SHALL win.
REQ-023 busy[0] SHALL be constant 0.
REQ-024 Requester SHALL hold valid/rd/data stable until ready; arbiter SHALL NOT depend on data for grant.
REQ-025 Starvation bound: a continuously valid requester SHALL be granted within 2 cycles.

Reset
REQ-026 While rst=1 at an edge: rf_we=0, rf_wa=0, rf_wd=0, busy=0, `last`=B (so A wins first contention).
REQ-027 a_ready and b_ready SHALL be 0 during any cycle rst=1; writes in flight in the output stage SHALL be dropped.
REQ-028 First handshake SHALL be possible on the first edge after rst deasserts.

Structure
REQ-029 Shared package SHALL hold register-address width (5), data width (32), register count (32) and the requester-id encoding (REQ_A=0, REQ_B=1).
REQ-030 Scoreboard SHALL be a separate sub-module rf_scoreboard (set/clear ports, busy vector); arbitration and output stage stay in rf_wb_arbiter.

Verification
REQ-031 After reset, a_valid=1, a_rd=5, a_data=0x1234 only -> a_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0x1234.
REQ-032 A and B valid continuously for 4 cycles (rd 1/2) -> grants A,B,A,B; rf_wa sequence 1,2,1,2 each one cycle late.
REQ-033 b_valid=1, b_rd=0, b_data=0xFFFF -> b_ready=1; next cycle rf_we=0; busy unchanged.
REQ-034 iss_valid rd=7 -> busy[7]=1 next cycle; write rd=7 accepted -> busy[7]=0 one cycle after rf_we; same-edge iss rd=7 and rf_wa=7 -> busy[7] stays 1.
REQ-035 rst asserted the cycle after handshake on rd=9 -> rf_we=0 and busy=0 after the reset edge; A then wins the first A/B contention.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and requester-id encoding for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int RA_W     = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_i,
  input  logic [RA_W-1:0]     set_rd_i,
  input  logic                clr_i,
  input  logic [RA_W-1:0]     clr_rd_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign set_vec[gi] = set_i && (set_rd_i == RA_W'(gi));
      assign clr_vec[gi] = clr_i && (clr_rd_i == RA_W'(gi));
    end
  endgenerate

  // Set is applied after clear so an issue on the same edge as the writeback wins.
  always_comb begin
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester round-robin writeback arbiter with a registered register-file write port
// and an attached pending-write scoreboard.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [RA_W-1:0]     a_rd,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [RA_W-1:0]     b_rd,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  input  logic                iss_valid,
  input  logic [RA_W-1:0]     iss_rd,
  output logic                rf_we,
  output logic [RA_W-1:0]     rf_wa,
  output logic [DATA_W-1:0]   rf_wd,
  output logic [NUM_REGS-1:0] busy
);

  req_id_e             last_q, last_d;
  logic                rf_we_q, rf_we_d;
  logic [RA_W-1:0]     rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0]   rf_wd_q, rf_wd_d;
  logic                hs_a;
  logic                hs_b;

  // Grant depends only on valids and the pointer; A wins contention when B went last.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      if (a_valid && (!b_valid || last_q == REQ_B)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  assign hs_a = a_valid && a_ready;
  assign hs_b = b_valid && b_ready;

  always_comb begin
    last_d  = last_q;
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (hs_a) begin
      last_d  = REQ_A;
      rf_we_d = (a_rd != '0);
      rf_wa_d = a_rd;
      rf_wd_d = a_data;
    end else if (hs_b) begin
      last_d  = REQ_B;
      rf_we_d = (b_rd != '0);
      rf_wa_d = b_rd;
      rf_wd_d = b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= REQ_B;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      last_q  <= last_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_i    (iss_valid),
    .set_rd_i (iss_rd),
    .clr_i    (rf_we_q),
    .clr_rd_i (rf_wa_q),
    .busy_o   (busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: grants, registered write port, scoreboard, reset.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_rd, b_rd, iss_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; iss_valid = 0;
    a_rd = 0; b_rd = 0; iss_rd = 0; a_data = 0; b_data = 0;
    step();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hDEAD;
    #1;
    check("rst_a_ready", {31'b0, a_ready}, 32'd0);
    step();
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("rst_rf_wa", {27'b0, rf_wa}, 32'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_busy", busy, 32'd0);

    // single A write right after reset
    rst = 1'b0; a_rd = 5'd5; a_data = 32'h1234;
    #1;
    check("a_only_a_ready", {31'b0, a_ready}, 32'd1);
    check("a_only_b_ready", {31'b0, b_ready}, 32'd0);
    step();
    a_valid = 1'b0;
    check("a_only_rf_we", {31'b0, rf_we}, 32'd1);
    check("a_only_rf_wa", {27'b0, rf_wa}, 32'd5);
    check("a_only_rf_wd", rf_wd, 32'h1234);
    step();
    check("idle_rf_we", {31'b0, rf_we}, 32'd0);

    // B write to x0: handshake, no register-file write; pointer now at B
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF;
    #1;
    check("b_x0_b_ready", {31'b0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    check("b_x0_rf_we", {31'b0, rf_we}, 32'd0);
    check("b_x0_busy", busy, 32'd0);

    // contention for four cycles: A,B,A,B
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_a_ready", i), {31'b0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_b_ready", i), {31'b0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check($sformatf("rr%0d_rf_we", i), {31'b0, rf_we}, 32'd1);
      check($sformatf("rr%0d_rf_wa", i), {27'b0, rf_wa}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr%0d_rf_wd", i), rf_wd, (i % 2 == 0) ? 32'hA1 : 32'hB2);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // scoreboard set, then clear one cycle after rf_we
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    check("sb_set7", busy, 32'h0000_0080);
    iss_valid = 1'b1; iss_rd = 5'd0;
    step();
    iss_valid = 1'b0;
    check("sb_x0_ignored", busy, 32'h0000_0080);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    step();
    a_valid = 1'b0;
    check("sb_wb7_rf_we", {31'b0, rf_we}, 32'd1);
    check("sb_wb7_still_busy", busy, 32'h0000_0080);
    step();
    check("sb_clr7", busy, 32'd0);

    // same-edge set and clear of x7: set wins
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h78;
    step();
    a_valid = 1'b0;
    check("sb_race_rf_wa", {27'b0, rf_wa}, 32'd7);
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    check("sb_race_set_wins", busy, 32'h0000_0080);

    // reset right after a handshake on x9 drops the write and the scoreboard
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
    step();
    check("pre_rst_rf_wa", {27'b0, rf_wa}, 32'd9);
    rst = 1'b1; a_rd = 5'd10;
    #1;
    check("in_rst_a_ready", {31'b0, a_ready}, 32'd0);
    step();
    check("post_rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("post_rst_busy", busy, 32'd0);
    check("post_rst_rf_wa", {27'b0, rf_wa}, 32'd0);
    rst = 1'b0;
    b_valid = 1'b1; b_rd = 5'd11; b_data = 32'hBB;
    #1;
    check("post_rst_a_wins", {31'b0, a_ready}, 32'd1);
    check("post_rst_b_waits", {31'b0, b_ready}, 32'd0);
    step();
    a_valid = 1'b0;
    check("post_rst_wa", {27'b0, rf_wa}, 32'd10);
    #1;
    check("post_rst_b_next", {31'b0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    check("post_rst_b_wa", {27'b0, rf_wa}, 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
